// File: rtl/dmem_ctrl.sv
// Byte-addressable RV32 data memory with optional zero-fill after reset and alignment/range fault checks.
// Latency: every accepted request gets one response LAT cycles after the accept edge; responses stay in order.
// Backpressure: req_ready is low only while clearing; the response side cannot stall.
module dmem_ctrl #(
    parameter int DEPTH          = 256,
    parameter int LAT            = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d;

    logic [31:0]   mem [DEPTH];
    rsp_t          pipe_q [LAT];
    rsp_t          pipe_d [LAT];

    logic          req_acc;
    logic [AW-1:0] word_idx;
    logic [31:0]   word_dat;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic          fault;
    logic          st_we;
    logic [3:0]    st_be;
    logic [31:0]   st_dat;
    logic [31:0]   ld_dat;

    // A request only counts when the controller is running and not being reset.
    assign req_acc  = req_valid && rdy_q && !rst;
    assign word_idx = req_addr[AW+1:2];
    assign word_dat = mem[word_idx];

    // Fault detection: out of range, misaligned, reserved width code, or unsigned-width store.
    always_comb begin
        fault = 1'b0;
        if (|req_addr[31:AW+2]) fault = 1'b1;
        case (req_funct3)
            3'b001, 3'b101: if (req_addr[0])         fault = 1'b1;
            3'b010:         if (req_addr[1:0] != 0)  fault = 1'b1;
            3'b011, 3'b110, 3'b111:                  fault = 1'b1;
            default: ;
        endcase
        if (req_we && (req_funct3 == 3'b100 || req_funct3 == 3'b101)) fault = 1'b1;
    end

    // Lane selection and sign/zero extension for loads; lane enables and replicated data for stores.
    always_comb begin
        byte_sel = word_dat[7:0];
        case (req_addr[1:0])
            2'd0: byte_sel = word_dat[7:0];
            2'd1: byte_sel = word_dat[15:8];
            2'd2: byte_sel = word_dat[23:16];
            2'd3: byte_sel = word_dat[31:24];
            default: ;
        endcase
        half_sel = req_addr[1] ? word_dat[31:16] : word_dat[15:0];
        ld_dat   = '0;
        st_be    = 4'b0000;
        st_dat   = req_wdata;
        case (req_funct3)
            3'b000: begin
                ld_dat = {{24{byte_sel[7]}}, byte_sel};
                st_be  = 4'b0001 << req_addr[1:0];
                st_dat = {4{req_wdata[7:0]}};
            end
            3'b100: ld_dat = {24'h0, byte_sel};
            3'b001: begin
                ld_dat = {{16{half_sel[15]}}, half_sel};
                st_be  = req_addr[1] ? 4'b1100 : 4'b0011;
                st_dat = {2{req_wdata[15:0]}};
            end
            3'b101: ld_dat = {16'h0, half_sel};
            3'b010: begin
                ld_dat = word_dat;
                st_be  = 4'b1111;
            end
            default: ;
        endcase
        st_we = req_acc && req_we && !fault;
    end

    // Next-state logic: walk the clear counter through every word, then open for requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                rdy_d   = 1'b1;
            end
        end
    end

    // Controller state register; ready/init_done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
            rdy_q   <= !CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    // Array writes: zero-fill while clearing, lane-masked stores while running; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem[cnt_q] <= '0;
            end else if (st_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (st_be[b]) mem[word_idx][8*b +: 8] <= st_dat[8*b +: 8];
                end
            end
        end
    end

    // Response shift pipeline: stage 0 captures the accepted request, the last stage drives the outputs.
    always_comb begin
        pipe_d[0].vld = req_acc;
        pipe_d[0].err = req_acc && fault;
        pipe_d[0].dat = (req_acc && !fault && !req_we) ? ld_dat : 32'h0;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LAT; i++) begin
            if (rst) pipe_q[i] <= '0;
            else     pipe_q[i] <= pipe_d[i];
        end
    end

    assign req_ready = rdy_q;
    assign init_done = rdy_q;
    assign rsp_valid = pipe_q[LAT-1].vld;
    assign rsp_err   = pipe_q[LAT-1].err;
    assign rsp_rdata = pipe_q[LAT-1].dat;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: four instances share the request bus (LAT 1/3/4 with clear, LAT 2 without).
// Latency: responses are logged per instance with the edge that captures them, then matched to accept edges.
// Backpressure: instances still clearing ignore requests; only the running ones respond.
module tb_dmem_ctrl;

    typedef struct packed {
        logic [31:0] edge_n;
        logic        err;
        logic [31:0] dat;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_init_done;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_init_done;
    logic        c_req_ready, c_rsp_valid, c_rsp_err, c_init_done;
    logic        d_req_ready, d_rsp_valid, d_rsp_err, d_init_done;
    logic [31:0] a_rsp_rdata, b_rsp_rdata, c_rsp_rdata, d_rsp_rdata;

    logic [31:0] cyc = '0;
    logic [31:0] rel_edge;
    int          n_vec = 0;
    int          n_err = 0;

    rec_t        qa[$];
    rec_t        qb[$];
    rec_t        qc[$];
    rec_t        qd[$];
    logic [31:0] accq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_ctrl #(.DEPTH(256), .LAT(1), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .init_done(a_init_done));

    dmem_ctrl #(.DEPTH(256), .LAT(3), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .init_done(b_init_done));

    dmem_ctrl #(.DEPTH(256), .LAT(4), .CLEAR_ON_RESET(1'b1)) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(c_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(c_rsp_valid),
        .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err), .init_done(c_init_done));

    dmem_ctrl #(.DEPTH(16), .LAT(2), .CLEAR_ON_RESET(1'b0)) u_d (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(d_rsp_valid),
        .rsp_rdata(d_rsp_rdata), .rsp_err(d_rsp_err), .init_done(d_init_done));

    // Response loggers: each entry records the clock edge that would capture the response.
    always @(negedge clk) if (a_rsp_valid) qa.push_back(rec_t'{cyc + 1, a_rsp_err, a_rsp_rdata});
    always @(negedge clk) if (b_rsp_valid) qb.push_back(rec_t'{cyc + 1, b_rsp_err, b_rsp_rdata});
    always @(negedge clk) if (c_rsp_valid) qc.push_back(rec_t'{cyc + 1, c_rsp_err, c_rsp_rdata});
    always @(negedge clk) if (d_rsp_valid) qd.push_back(rec_t'{cyc + 1, d_rsp_err, d_rsp_rdata});

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic flush();
        qa.delete();
        qb.delete();
        qc.delete();
        qd.delete();
        accq.delete();
    endtask

    // Drive one request at a negedge, log its accept edge, return at the following negedge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        accq.push_back(cyc);
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Pop the next response of instance sel and compare error, data and accept-to-response latency.
    task automatic chk_rsp(input int sel, input string tag, input logic err, input logic [31:0] dat,
                           input int lat);
        rec_t        r;
        bit          got;
        logic [31:0] acc;
        got = 1'b0;
        r   = '0;
        for (int i = 0; i < 16 && !got; i++) begin
            #1;
            case (sel)
                0: if (qa.size() > 0) begin r = qa.pop_front(); got = 1'b1; end
                1: if (qb.size() > 0) begin r = qb.pop_front(); got = 1'b1; end
                2: if (qc.size() > 0) begin r = qc.pop_front(); got = 1'b1; end
                default: if (qd.size() > 0) begin r = qd.pop_front(); got = 1'b1; end
            endcase
            if (!got) @(negedge clk);
        end
        if (!got) begin
            check_val({tag, "_seen"}, 32'd0, 32'd1);
        end else begin
            acc = (accq.size() > 0) ? accq.pop_front() : 32'd0;
            check_val({tag, "_err"}, {31'd0, r.err}, {31'd0, err});
            check_val({tag, "_dat"}, r.dat, dat);
            check_val({tag, "_lat"}, r.edge_n - acc, 32'(lat));
        end
    endtask

    // Wait (bounded) for instance A to finish clearing and compare the clear length to DEPTH.
    task automatic wait_clear(input string tag, input logic [31:0] rel);
        for (int i = 0; i < 400 && !a_req_ready; i++) @(negedge clk);
        check_val(tag, cyc - rel, 32'd256);
        check_val({tag, "_init"}, {31'd0, a_init_done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", {31'd0, a_rsp_valid}, 32'd0);
        check_val("rst_rdata", a_rsp_rdata, 32'd0);
        check_val("rst_err",   {31'd0, a_rsp_err}, 32'd0);
        check_val("rst_ready", {31'd0, a_req_ready}, 32'd0);
        check_val("rst_init",  {31'd0, a_init_done}, 32'd0);
        rst = 1'b0;
        rel_edge = cyc;
        check_val("noclr_ready", {31'd0, d_req_ready}, 32'd1);
        check_val("noclr_init",  {31'd0, d_init_done}, 32'd1);

        // Clear length and top word reads zero
        wait_clear("clear_cycles", rel_edge);
        flush();
        issue(1'b0, 3'b010, 32'h3FC, 32'h0);
        idle();
        chk_rsp(0, "lw_3fc", 1'b0, 32'h0, 1);

        // Byte lanes and extension, back-to-back
        flush();
        issue(1'b1, 3'b010, 32'h100, 32'h11223344);
        issue(1'b1, 3'b000, 32'h101, 32'h000000A5);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        issue(1'b0, 3'b000, 32'h101, 32'h0);
        issue(1'b0, 3'b100, 32'h101, 32'h0);
        issue(1'b0, 3'b001, 32'h102, 32'h0);
        idle();
        chk_rsp(0, "sw_100",  1'b0, 32'h0, 1);
        chk_rsp(0, "sb_101",  1'b0, 32'h0, 1);
        chk_rsp(0, "lw_100",  1'b0, 32'h1122A544, 1);
        chk_rsp(0, "lb_101",  1'b0, 32'hFFFFFFA5, 1);
        chk_rsp(0, "lbu_101", 1'b0, 32'h000000A5, 1);
        chk_rsp(0, "lh_102",  1'b0, 32'h00001122, 1);

        // Faults and halfword extension
        flush();
        issue(1'b0, 3'b010, 32'h102, 32'h0);
        issue(1'b1, 3'b001, 32'h001, 32'h0000BEEF);
        issue(1'b0, 3'b010, 32'h000, 32'h0);
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        issue(1'b1, 3'b100, 32'h100, 32'h00000055);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        issue(1'b1, 3'b001, 32'h104, 32'h00008001);
        issue(1'b0, 3'b001, 32'h104, 32'h0);
        issue(1'b0, 3'b101, 32'h104, 32'h0);
        idle();
        chk_rsp(0, "lw_mis",   1'b1, 32'h0, 1);
        chk_rsp(0, "sh_mis",   1'b1, 32'h0, 1);
        chk_rsp(0, "lw_000",   1'b0, 32'h0, 1);
        chk_rsp(0, "lw_oob",   1'b1, 32'h0, 1);
        chk_rsp(0, "f3_011",   1'b1, 32'h0, 1);
        chk_rsp(0, "st_bu",    1'b1, 32'h0, 1);
        chk_rsp(0, "lw_keep",  1'b0, 32'h1122A544, 1);
        chk_rsp(0, "sh_104",   1'b0, 32'h0, 1);
        chk_rsp(0, "lh_104",   1'b0, 32'hFFFF8001, 1);
        chk_rsp(0, "lhu_104",  1'b0, 32'h00008001, 1);

        // LAT=3 store then load on consecutive cycles
        repeat (8) @(negedge clk);
        flush();
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        idle();
        chk_rsp(1, "l3_sw", 1'b0, 32'h0, 3);
        chk_rsp(1, "l3_lw", 1'b0, 32'hDEADBEEF, 3);

        // Reset two cycles after accepting a LAT=4 load
        repeat (8) @(negedge clk);
        flush();
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rel_edge = cyc;
        flush();

        // Instance without clear keeps its contents and serves requests while others clear
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        idle();
        chk_rsp(3, "noclr_keep", 1'b0, 32'hDEADBEEF, 2);
        repeat (6) @(negedge clk);
        #1;
        check_val("l4_dropped", 32'(qc.size()), 32'd0);
        check_val("clr_ignore", 32'(qa.size()), 32'd0);
        check_val("reclr_ready", {31'd0, c_req_ready}, 32'd0);

        // Clear restarted from word 0 and wiped the earlier store
        wait_clear("reclear_cycles", rel_edge);
        flush();
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        idle();
        chk_rsp(0, "recleared", 1'b0, 32'h0, 1);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
